// File: rtl/crossover_sched.sv
// Job sequencer for the crossover_perturb datapath: config load, gene streaming,
// valid-pipe tracking and a credit-controlled child FIFO. Optional stall counter: CROSSOVER_SCHED_STALL_CNT_EN.
module crossover_sched #(
    parameter int GENE_SZ = 64,
    parameter int WORD_SZ = 32,
    parameter int ATTR_SZ = 8,
    parameter int CNT_SZ  = 8,
    parameter int DEPTH   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [GENE_SZ-1:0] cmd_cfg,
    input  logic [ATTR_SZ-1:0] cmd_child_id,
    input  logic [CNT_SZ-1:0]  cmd_num_genes,
    input  logic               gene_valid,
    output logic               gene_ready,
    input  logic [GENE_SZ-1:0] gene1_in,
    input  logic [GENE_SZ-1:0] gene2_in,
    input  logic [WORD_SZ-1:0] rng_in,
    output logic               rng_advance,
    output logic               cp_setup,
    output logic [GENE_SZ-1:0] cp_data_in1,
    output logic [GENE_SZ-1:0] cp_data_in2,
    output logic [WORD_SZ-1:0] cp_random,
    input  logic [GENE_SZ-1:0] cp_child_gene,
    output logic               child_valid,
    input  logic               child_ready,
    output logic [GENE_SZ-1:0] child_gene,
    output logic               child_last,
    output logic               busy,
    output logic               done,
    output logic [15:0]        stall_cycles
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SUM_W = PTR_W + 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ISSUE,
        S_DRAIN
    } state_t;

    state_t             state_q, state_d;
    logic [GENE_SZ-1:0] cfg_q, cfg_d;
    logic [ATTR_SZ-1:0] id_q, id_d;
    logic [CNT_SZ-1:0]  rem_q, rem_d;

    logic               cp_setup_q, cp_setup_d;
    logic [GENE_SZ-1:0] cp_in1_q, cp_in1_d;
    logic [GENE_SZ-1:0] cp_in2_q, cp_in2_d;
    logic [WORD_SZ-1:0] cp_rand_q, cp_rand_d;

    logic [3:0]         pipe_vld_q, pipe_vld_d;
    logic [3:0]         pipe_last_q, pipe_last_d;

    logic [GENE_SZ:0]   fifo_mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   fifo_cnt_q, fifo_cnt_d;

    logic [2:0]         inflight;
    logic               credit;
    logic               handshake;
    logic               accept;
    logic               push;
    logic               pop;

    // Credit counts children already in the pipe so a push can never find the FIFO full.
    assign inflight  = {2'b00, pipe_vld_q[0]} + {2'b00, pipe_vld_q[1]}
                     + {2'b00, pipe_vld_q[2]} + {2'b00, pipe_vld_q[3]};
    assign credit    = (SUM_W'(fifo_cnt_q) + SUM_W'(inflight)) < SUM_W'(DEPTH);
    assign handshake = (state_q == S_ISSUE) && gene_valid && credit;
    assign accept    = (state_q == S_IDLE) && cmd_valid;
    assign push      = pipe_vld_q[3];
    assign pop       = child_valid && child_ready;

    assign cmd_ready   = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign gene_ready  = handshake;
    assign rng_advance = handshake;
    assign done        = (state_q == S_DRAIN) && (inflight == 3'd0);

    assign cp_setup    = cp_setup_q;
    assign cp_data_in1 = cp_in1_q;
    assign cp_data_in2 = cp_in2_q;
    assign cp_random   = cp_rand_q;

    assign child_valid = (fifo_cnt_q != '0);
    assign child_gene  = fifo_mem[rd_ptr_q][GENE_SZ-1:0];
    assign child_last  = child_valid && fifo_mem[rd_ptr_q][GENE_SZ];

    // NOTE: every variable gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        cfg_d   = cfg_q;
        id_d    = id_q;
        rem_d   = rem_q;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    cfg_d   = cmd_cfg;
                    id_d    = cmd_child_id;
                    rem_d   = cmd_num_genes;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                state_d = (rem_q != '0) ? S_ISSUE : S_DRAIN;
            end
            S_ISSUE: begin
                if (handshake) begin
                    rem_d = rem_q - CNT_SZ'(1);
                    if (rem_q == CNT_SZ'(1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (inflight == 3'd0) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath inputs are registered; idle/setup keep the config loaded so reloads are harmless.
    always_comb begin
        cp_setup_d = (state_d == S_IDLE) || (state_d == S_SETUP);
        cp_in1_d   = cp_in1_q;
        cp_in2_d   = cp_in2_q;
        cp_rand_d  = cp_rand_q;
        if ((state_d == S_IDLE) || (state_d == S_SETUP)) begin
            cp_in1_d = cfg_d;
            cp_in2_d = GENE_SZ'(id_d);
        end else if (handshake) begin
            cp_in1_d  = gene1_in;
            cp_in2_d  = gene2_in;
            cp_rand_d = rng_in;
        end
    end

    always_comb begin
        pipe_vld_d  = {pipe_vld_q[2:0], handshake};
        pipe_last_d = {pipe_last_q[2:0], handshake && (rem_q == CNT_SZ'(1))};
    end

    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        unique case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cfg_q       <= '0;
            id_q        <= '0;
            rem_q       <= '0;
            cp_setup_q  <= 1'b1;
            cp_in1_q    <= '0;
            cp_in2_q    <= '0;
            cp_rand_q   <= '0;
            pipe_vld_q  <= '0;
            pipe_last_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fifo_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            cfg_q       <= cfg_d;
            id_q        <= id_d;
            rem_q       <= rem_d;
            cp_setup_q  <= cp_setup_d;
            cp_in1_q    <= cp_in1_d;
            cp_in2_q    <= cp_in2_d;
            cp_rand_q   <= cp_rand_d;
            pipe_vld_q  <= pipe_vld_d;
            pipe_last_q <= pipe_last_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fifo_cnt_q  <= fifo_cnt_d;
        end
    end

    // NOTE: storage is not reset; emptiness comes from the reset pointers and count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {pipe_last_q[3], cp_child_gene};
        end
    end

`ifdef CROSSOVER_SCHED_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (accept) begin
            stall_d = '0;
        end else if ((state_q == S_ISSUE) && gene_valid && !credit && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`else
    logic unused_accept;
    assign unused_accept = accept;
    assign stall_cycles  = '0;
`endif

endmodule

// File: doc/crossover_sched.md
# crossover_sched

Sequencer for the `crossover_perturb` datapath. It accepts one child-generation job at a time:
- a configuration word carrying parent fitnesses and mutation probabilities;
- a child genome id and a gene count.

It loads the configuration into the datapath with a `setup` cycle, then streams parent gene pairs and random words into it. Children returning from the datapath pipeline are tracked by an internal valid pipe and buffered in a credit-controlled output FIFO. It sits between the genome memory/LFSR front end and the child-genome writer.

## Interface
- `GENE_SZ`, default 64: gene and config word width.
- `WORD_SZ`, default 32: random word width.
- `ATTR_SZ`, default 8: genome id width.
- `CNT_SZ`, default 8: gene count width.
- `DEPTH`, default 4: output FIFO entries, a power of two, at least 4.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous and active-low.
- `cmd_valid`  in  1  job request.
- `cmd_ready`  out  1  job accept; high only in IDLE.
- `cmd_cfg`  in  GENE_SZ  fitness/mutation-probability word.
- `cmd_child_id`  in  ATTR_SZ  child genome id.
- `cmd_num_genes`  in  CNT_SZ  gene pairs in the job.
- `gene_valid`  in  1  parent pair available.
- `gene_ready`  out  1  parent pair accepted.
- `gene1_in`, `gene2_in`  in  GENE_SZ  parent genes.
- `rng_in`  in  WORD_SZ  current LFSR word.
- `rng_advance`  out  1  one-cycle pulse per consumed word.
- `cp_setup`  out  1  datapath `setup`.
- `cp_data_in1`, `cp_data_in2`  out  GENE_SZ  datapath data inputs.
- `cp_random`  out  WORD_SZ  datapath `random_num_pack`.
- `cp_child_gene`  in  GENE_SZ  datapath `child_gene`.
- `child_valid`  out  1  FIFO head valid.
- `child_ready`  in  1  pop FIFO head.
- `child_gene`  out  GENE_SZ  FIFO head gene.
- `child_last`  out  1  head is the last gene of its job.
- `busy`  out  1  state is not IDLE.
- `done`  out  1  one-cycle pulse at job end.
- `stall_cycles`  out  16  credit-stall count (see Configuration).

## Operation
- States: IDLE, SETUP, ISSUE, DRAIN.
- **IDLE:**
  - `cmd_ready`=1 and `cp_setup`=1.
  - `cp_data_in1`=`cfg_q`; `cp_data_in2`=`{0, id_q}`. Repeated reloads of the datapath are idempotent.
  - On `cmd_valid`: latch `cfg_q`, `id_q`, `rem`=`cmd_num_genes`; drive `cp_data_in*` with the new values; go to SETUP.
- **SETUP:**
  - Lasts exactly one cycle, with `cp_setup`=1.
  - On exit, `cp_setup`<=0.
  - Go to ISSUE if `rem`≠0, else DRAIN.
- **ISSUE:**
  - `gene_ready`=`gene_valid` && (`fifo_cnt` + `inflight` < `DEPTH`).
  - On handshake:
    - `cp_data_in1`/`cp_data_in2`<=genes;
    - `cp_random`<=`rng_in`;
    - `rng_advance`=1;
    - `pipe[0]`<={1, `rem`==1};
    - `rem`-=1.
  - With no handshake, `pipe[0]`<=0; the datapath computes a bubble that is discarded.
  - Go to DRAIN on the handshake where `rem`==1.
- **DRAIN:**
  - `cp_setup`=0; `gene_ready`=0.
  - When `inflight`==0: pulse `done`, go to IDLE.
- **Valid pipe:**
  - 4 stages; `pipe[k+1]`<=`pipe[k]` every cycle.
  - When `pipe[3]` is valid, push `{last, cp_child_gene}` into the FIFO.
  - `inflight` = number of valid pipe stages.
- **FIFO:**
  - Simultaneous push and pop is allowed.
  - The credit rule guarantees no push when full.
  - `child_*` reflect the head combinationally.
- `cmd_num_genes`=0: the job completes with `done` and produces no children.

## Timing
- Job accepted at edge C: datapath loads the config at C+1; the first gene handshake can occur at C+2.
- Gene handshake at edge A: FIFO push at A+4; `child_valid` is high after A+4 if the FIFO was empty.
- Throughput: one gene per cycle while credit holds.
- The last handshake at A_L: `done` is high during the cycle after A_L+4; next `cmd_ready` follows one cycle after that.
- Reset values:
  - state=IDLE, so `cmd_ready`=1;
  - `cp_setup`=1;
  - `cp_data_in*`, `cp_random`, `cfg_q`, `id_q`=0;
  - `rng_advance`, `gene_ready`, `child_valid`, `child_last`, `busy`, `done`=0;
  - `stall_cycles`=0;
  - pipe and FIFO empty.
- Reset mid-job discards all in-flight and buffered children.

## Configuration
- `CROSSOVER_SCHED_STALL_CNT_EN` defined:
  - `stall_cycles` increments in ISSUE on each cycle with `gene_valid`=1 and no credit;
  - it saturates at 0xFFFF and clears on each job accept.
- Undefined: `stall_cycles` is tied to 0 and no counter is built.

## Test plan
- **Single job:** `cmd_num_genes`=3, genes always valid, `child_ready`=1.
  - Exactly 3 children; `child_last` only on the third.
  - `done` pulses exactly 5 cycles after the third handshake.
  - `rng_advance` pulses exactly 3 times.
- **Backpressure:** 8 genes, `child_ready`=0.
  - `gene_ready` drops after 4 handshakes.
  - When `child_ready` is raised, all 8 children emerge in order with no loss.
  - With the macro defined, `stall_cycles`>0.
- **Zero-gene job:** `cmd_num_genes`=0.
  - No `child_valid`; `done` pulses.
  - `cmd_ready` returns within 5 cycles of the accept.
- **Bubbles:** `gene_valid` toggles every cycle over 4 genes.
  - Exactly 4 children; no bubble is pushed.
- **Reset mid-job:** `rst` low at the second handshake.
  - All outputs take their reset values immediately.
  - After release, a new 2-gene job yields exactly 2 children.
- **Back-to-back jobs:** ids 0x11 then 0x22.
  - Upper byte of every child equals its own job's id.
  - `cp_setup` is never 0 in IDLE or SETUP.
